// File: rtl/operand_latch.sv
// Decode/execute boundary latch: resolves source operands through the
// EX/MEM and MEM/WB forwarding paths, inserts a single bubble on a
// load-use dependency, and registers the result into the execute stage.
module operand_latch #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [DW-1:0] id_rdat1,
    input  logic [DW-1:0] id_rdat2,
    input  logic [DW-1:0] id_imm,
    input  logic [AW-1:0] id_wsel,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          exmem_regwrite,
    input  logic [AW-1:0] exmem_wsel,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [AW-1:0] memwb_wsel,
    input  logic [DW-1:0] memwb_wdat,
    input  logic          ex_stall,
    input  logic          flush,
    output logic          id_hold,
    output logic          ex_valid,
    output logic [DW-1:0] ex_opa,
    output logic [DW-1:0] ex_opb,
    output logic [DW-1:0] ex_imm,
    output logic [AW-1:0] ex_wsel,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic [CW-1:0] stall_count
);

    typedef logic [DW-1:0] word_t;

    word_t fwd_a;
    word_t fwd_b;
    logic  load_use;

    // Youngest producer wins; register 0 is hardwired and never forwarded.
    // MEM/WB covers the write landing in the register file at this same edge.
    function automatic word_t resolve(
        input logic [AW-1:0] src,
        input word_t         base,
        input logic          em_we,
        input logic [AW-1:0] em_sel,
        input word_t         em_dat,
        input logic          wb_we,
        input logic [AW-1:0] wb_sel,
        input word_t         wb_dat
    );
        word_t val;
        if (src == '0)
            val = '0;
        else if (em_we && (em_sel == src))
            val = em_dat;
        else if (wb_we && (wb_sel == src))
            val = wb_dat;
        else
            val = base;
        return val;
    endfunction

    // Operand resolution and load-use detection against the instruction now in EX.
    always_comb begin
        fwd_a    = resolve(id_rs, id_rdat1, exmem_regwrite, exmem_wsel, exmem_result,
                           memwb_regwrite, memwb_wsel, memwb_wdat);
        fwd_b    = resolve(id_rt, id_rdat2, exmem_regwrite, exmem_wsel, exmem_result,
                           memwb_regwrite, memwb_wsel, memwb_wdat);
        load_use = ex_valid && ex_memread && (ex_wsel != '0) && id_valid &&
                   ((ex_wsel == id_rs) || (ex_wsel == id_rt));
        id_hold  = load_use | ex_stall;
    end

    // Pipeline register: flush beats stall beats bubble beats capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_valid    <= 1'b0;
            ex_opa      <= '0;
            ex_opb      <= '0;
            ex_imm      <= '0;
            ex_wsel     <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            stall_count <= '0;
        end else if (flush) begin
            // Data fields are left as they were; only the control is squashed.
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (ex_stall) begin
            // Hold everything; operands stay as resolved at capture time.
        end else if (load_use) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            if (stall_count != '1)
                stall_count <= stall_count + CW'(1);
        end else begin
            ex_valid    <= id_valid;
            ex_opa      <= fwd_a;
            ex_opb      <= fwd_b;
            ex_imm      <= id_imm;
            ex_wsel     <= id_wsel;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread & id_valid;
        end
    end

endmodule

// File: tb/tb_operand_latch.sv
// Bench for operand_latch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_operand_latch;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_wsel = '0;
    logic [31:0] id_rdat1 = '0, id_rdat2 = '0, id_imm = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0;
    logic        exmem_regwrite = 1'b0;
    logic [4:0]  exmem_wsel = '0;
    logic [31:0] exmem_result = '0;
    logic        memwb_regwrite = 1'b0;
    logic [4:0]  memwb_wsel = '0;
    logic [31:0] memwb_wdat = '0;
    logic        ex_stall = 1'b0, flush = 1'b0;

    logic        id_hold, ex_valid, ex_regwrite, ex_memread;
    logic [31:0] ex_opa, ex_opb, ex_imm;
    logic [4:0]  ex_wsel;
    logic [15:0] stall_count;

    logic        s_id_hold, s_ex_valid, s_ex_regwrite, s_ex_memread;
    logic [31:0] s_ex_opa, s_ex_opb, s_ex_imm;
    logic [4:0]  s_ex_wsel;
    logic [1:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    operand_latch #(.DW(32), .AW(5), .CW(16)) dut (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_wsel(id_wsel),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .exmem_regwrite(exmem_regwrite), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .ex_stall(ex_stall), .flush(flush), .id_hold(id_hold), .ex_valid(ex_valid),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_imm(ex_imm), .ex_wsel(ex_wsel),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .stall_count(stall_count)
    );

    operand_latch #(.DW(32), .AW(5), .CW(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_wsel(id_wsel),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .exmem_regwrite(exmem_regwrite), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .ex_stall(ex_stall), .flush(flush), .id_hold(s_id_hold), .ex_valid(s_ex_valid),
        .ex_opa(s_ex_opa), .ex_opb(s_ex_opb), .ex_imm(s_ex_imm), .ex_wsel(s_ex_wsel),
        .ex_regwrite(s_ex_regwrite), .ex_memread(s_ex_memread), .stall_count(s_stall_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The EX slot is modelled as "the instruction currently in execute".
    logic        m_valid = 0, m_rw = 0, m_mr = 0;
    logic [31:0] m_opa = 0, m_opb = 0, m_imm = 0;
    logic [4:0]  m_wsel = 0;
    int          m_sc = 0, m_sc_sat = 0;

    function automatic logic [31:0] m_value(input logic [4:0] r, input logic [31:0] rf_val);
        if (r == 0) return 32'd0;
        if (exmem_regwrite && exmem_wsel == r) return exmem_result;
        if (memwb_regwrite && memwb_wsel == r) return memwb_wdat;
        return rf_val;
    endfunction

    function automatic logic m_dep();
        return m_valid && m_mr && m_wsel != 0 && id_valid &&
               (m_wsel == id_rs || m_wsel == id_rt);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
            m_opa = 0; m_opb = 0; m_imm = 0; m_wsel = 0;
            m_sc = 0; m_sc_sat = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
        end else if (ex_stall) begin
            m_valid = m_valid;
        end else if (m_dep()) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
            m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
            m_sc_sat = (m_sc_sat < 3) ? m_sc_sat + 1 : 3;
        end else begin
            m_opa = m_value(id_rs, id_rdat1);
            m_opb = m_value(id_rt, id_rdat2);
            m_imm = id_imm; m_wsel = id_wsel;
            m_valid = id_valid;
            m_rw = id_regwrite && id_valid;
            m_mr = id_memread && id_valid;
        end
    end

    // Every falling edge: both instances against the model; data only while valid.
    always @(negedge CLK) begin
        chk("id_hold", 64'(id_hold), 64'(m_dep() || ex_stall));
        chk("ex_valid", 64'(ex_valid), 64'(m_valid));
        chk("ex_regwrite", 64'(ex_regwrite), 64'(m_rw));
        chk("ex_memread", 64'(ex_memread), 64'(m_mr));
        chk("stall_count", 64'(stall_count), 64'(m_sc));
        chk("sat_id_hold", 64'(s_id_hold), 64'(m_dep() || ex_stall));
        chk("sat_ex_valid", 64'(s_ex_valid), 64'(m_valid));
        chk("sat_ctrl", {62'd0, s_ex_regwrite, s_ex_memread}, {62'd0, m_rw, m_mr});
        chk("sat_stall_count", 64'(s_stall_count), 64'(m_sc_sat));
        if (m_valid) begin
            chk("ex_opa", 64'(ex_opa), 64'(m_opa));
            chk("ex_opb", 64'(ex_opb), 64'(m_opb));
            chk("ex_imm", 64'(ex_imm), 64'(m_imm));
            chk("ex_wsel", 64'(ex_wsel), 64'(m_wsel));
            chk("sat_data", {s_ex_opa, s_ex_opb}, {m_opa, m_opb});
            chk("sat_imm_wsel", {27'd0, s_ex_wsel, s_ex_imm}, {27'd0, m_wsel, m_imm});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rdat1 = 0; id_rdat2 = 0; id_imm = 0;
        id_wsel = 0; id_regwrite = 0; id_memread = 0;
        exmem_regwrite = 0; exmem_wsel = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_wsel = 0; memwb_wdat = 0;
        ex_stall = 0; flush = 0;
    endtask

    task automatic randomize_inputs();
        id_valid = ($urandom_range(0, 4) != 0);
        id_rs = 5'($urandom_range(0, 7));
        id_rt = 5'($urandom_range(0, 7));
        id_rdat1 = $urandom; id_rdat2 = $urandom; id_imm = $urandom;
        id_wsel = 5'($urandom_range(0, 7));
        id_regwrite = $urandom_range(0, 1) == 1;
        id_memread = ($urandom_range(0, 2) == 0);
        exmem_regwrite = $urandom_range(0, 1) == 1;
        exmem_wsel = 5'($urandom_range(0, 7));
        exmem_result = $urandom;
        memwb_regwrite = $urandom_range(0, 1) == 1;
        memwb_wsel = 5'($urandom_range(0, 7));
        memwb_wdat = $urandom;
    endtask

    logic [31:0] snap_opa, snap_opb, snap_imm;
    logic [4:0]  snap_wsel;
    logic        snap_valid, snap_rw;

    initial begin
        // Reset held for 3 cycles under random inputs.
        nRST = 0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            ex_stall = $urandom_range(0, 1) == 1;
            flush = $urandom_range(0, 1) == 1;
            @(negedge CLK);
            chk("rst_id_hold", 64'(id_hold), 64'(ex_stall));
            tick();
            chk("rst_outputs", {ex_valid, ex_regwrite, ex_memread, ex_wsel}, 64'd0);
            chk("rst_data", {ex_opa, ex_opb}, 64'd0);
            chk("rst_imm_count", {ex_imm, stall_count}, 64'd0);
        end

        // Forwarding priority on operand A.
        quiet();
        nRST = 1;
        id_valid = 1; id_regwrite = 1; id_wsel = 2;
        id_rs = 5; id_rdat1 = 32'h11;
        exmem_regwrite = 1; exmem_wsel = 5; exmem_result = 32'h22;
        memwb_regwrite = 1; memwb_wsel = 5; memwb_wdat = 32'h33;
        tick();
        chk("fwd_exmem", 64'(ex_opa), 64'h22);
        exmem_regwrite = 0;
        tick();
        chk("fwd_memwb", 64'(ex_opa), 64'h33);
        memwb_regwrite = 0;
        tick();
        chk("fwd_rf", 64'(ex_opa), 64'h11);

        // Register 0 is never forwarded.
        id_rt = 0; id_rdat2 = 32'h55;
        exmem_regwrite = 1; exmem_wsel = 0; exmem_result = 32'hDEAD;
        tick();
        chk("r0_opb", 64'(ex_opb), 64'h0);

        // Load-use: load to r7, then a consumer of r7 on rt.
        quiet();
        id_valid = 1; id_regwrite = 1; id_memread = 1; id_wsel = 7;
        tick();
        id_memread = 0; id_wsel = 9; id_rs = 3; id_rt = 7; id_rdat2 = 32'h99;
        @(negedge CLK);
        chk("lu_hold", 64'(id_hold), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
        chk("lu_count", 64'(stall_count), 64'd1);
        exmem_regwrite = 1; exmem_wsel = 7; exmem_result = 32'hABCD;
        @(negedge CLK);
        chk("lu_hold_released", 64'(id_hold), 64'd0);
        tick();
        chk("lu_capture", {ex_valid, ex_wsel, ex_opb}, {1'b1, 5'd9, 32'hABCD});

        // Stall for 4 cycles under changing inputs: everything holds.
        snap_opa = ex_opa; snap_opb = ex_opb; snap_imm = ex_imm;
        snap_wsel = ex_wsel; snap_valid = ex_valid; snap_rw = ex_regwrite;
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            ex_stall = 1;
            tick();
            chk("stall_hold", {ex_opa, ex_opb}, {snap_opa, snap_opb});
            chk("stall_hold_ctl", {snap_imm, 25'd0, snap_wsel, snap_valid, snap_rw},
                {ex_imm, 25'd0, ex_wsel, ex_valid, ex_regwrite});
            chk("stall_count_hold", 64'(stall_count), 64'd1);
        end
        flush = 1;
        tick();
        chk("flush_ctl", {ex_valid, ex_regwrite}, 64'd0);
        chk("flush_count", 64'(stall_count), 64'd1);

        // Back-to-back self-dependent loads: one bubble every two edges.
        quiet();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_wsel = 7; id_rs = 7;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_count", 64'(s_stall_count), 64'd3);
        chk("wide_count", 64'(stall_count), 64'd6);

        // Randomized traffic with occasional stall, flush and mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            ex_stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 19) == 0);
            nRST = ($urandom_range(0, 399) != 0);
            tick();
        end
        nRST = 1;
        quiet();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_latch.md
Name: operand_latch

Overview:
- Decode/execute boundary stage, directly downstream of the register file read ports.
- Combines register-file read data with forwarded results from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles.
- Registers the resolved operands and control into the execute stage, with stall and flush support.

Parameters:
- DW, 32, datapath width (word_t)
- AW, 5, register select width
- CW, 16, stall-statistics counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  AW  source select 1; same value as the register file rsel1
- id_rt  in  AW  source select 2; same value as the register file rsel2
- id_rdat1  in  DW  register file rdat1
- id_rdat2  in  DW  register file rdat2
- id_imm  in  DW  extended immediate
- id_wsel  in  AW  destination register
- id_regwrite  in  1  instruction writes a register
- id_memread  in  1  instruction is a load
- exmem_regwrite  in  1  EX/MEM stage will write a register
- exmem_wsel  in  AW  EX/MEM stage destination register
- exmem_result  in  DW  EX/MEM stage result
- memwb_regwrite  in  1  register file WEN this cycle
- memwb_wsel  in  AW  register file wsel
- memwb_wdat  in  DW  register file wdat
- ex_stall  in  1  execute stage cannot accept
- flush  in  1  squash the instruction entering this stage
- id_hold  out  1  decode stage must hold its contents this cycle
- ex_valid  out  1  registered valid
- ex_opa  out  DW  registered operand A
- ex_opb  out  DW  registered operand B
- ex_imm  out  DW  registered immediate
- ex_wsel  out  AW  registered destination
- ex_regwrite  out  1  registered write enable
- ex_memread  out  1  registered load flag
- stall_count  out  CW  count of load-use bubbles inserted

Behaviour:
- Reset: every registered output, including stall_count, is 0 asynchronously while nRST is low. This yields a bubble. Reset mid-stall drops the held instruction.
- Forwarding is combinational and applies per operand. For operand A, with src = id_rs and base = id_rdat1, the first match wins:
  - src == 0: value is 0.
  - exmem_regwrite and exmem_wsel == src: value is exmem_result.
  - memwb_regwrite and memwb_wsel == src: value is memwb_wdat. This covers the same-cycle write, because the register file updates only at the edge.
  - Otherwise: value is base.
- Operand B uses the same priority with src = id_rt and base = id_rdat2.
- load_use is asserted when all of the following hold:
  - ex_valid and ex_memread
  - ex_wsel != 0
  - id_valid
  - ex_wsel == id_rs or ex_wsel == id_rt
- id_hold = load_use | ex_stall. It is combinational.
- Register update priority, per rising edge:
  1. flush: ex_valid, ex_regwrite and ex_memread are set to 0. Data fields hold. flush overrides ex_stall and load_use.
  2. ex_stall: all outputs hold their values.
  3. load_use: insert a bubble (valid and control = 0). stall_count increments, saturating at all ones.
  4. Otherwise: capture the forwarded operands, id_imm, id_wsel, and the control bits ANDed with id_valid.
- Latency: 1 cycle from the decode inputs to the ex_* outputs. A load-use case costs exactly 1 bubble. After the bubble, the load is in EX/MEM and its result is taken via the forwarding path on the following edge.
- A write to register 0 on any forwarding path is ignored. The latch's own destination 0 never triggers load_use.
- During ex_stall the latch does not re-sample forwarding. Operands were resolved when the instruction was captured.
- Simultaneous load_use and ex_stall: hold; stall_count does not increment.
- Simultaneous load_use and flush: flush; stall_count does not increment.

Test Plan:
- Reset: hold nRST low for 3 cycles, with all inputs randomised → all ex_* outputs and stall_count are 0; id_hold follows ex_stall only.
- Forward priority: id_rs = 5, id_rdat1 = 0x11, exmem (1, 5, 0x22), memwb (1, 5, 0x33) → ex_opa = 0x22. Drop exmem_regwrite → ex_opa = 0x33. Drop both → ex_opa = 0x11.
- Register 0: id_rt = 0, exmem (1, 0, 0xDEAD) → ex_opb = 0.
- Load-use: load to r7 latched, next instruction has id_rt = 7 →
  - id_hold = 1 for 1 cycle.
  - Next edge: ex_valid = 0 and stall_count = 1.
  - Following edge: the dependent instruction is captured with exmem_result forwarded.
- Stall/flush: assert ex_stall for 4 cycles → outputs are stable. Then assert flush together with ex_stall → ex_valid = 0 and ex_regwrite = 0; stall_count is unchanged.
- Saturation: with CW = 2, force 5 load-use bubbles → stall_count = 3.
